fetch_byte_sequencer: RTL

Sequences instruction fetches from the byte-wide (DATA_WIDTH=8) instruction store. The store is a synchronous single-port byte memory with one read per cycle. The block sits between the PC/fetch stage and that memory. It accepts a word-fetch request, issues four consecutive byte reads, assembles the little-endian 32-bit instruction, and returns it over a valid/ready handshake. It also flags misaligned and out-of-window addresses and supports pipeline flush.

---
 rtl/fetch_byte_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_byte_sequencer.sv
// Fetch sequencer between the PC stage and a byte-wide synchronous instruction store.
// Issues four byte reads per word request and returns the little-endian instruction.
module fetch_byte_sequencer #(
  parameter int                         ADDRESS_WIDTH  = 32,
  parameter int                         DATA_WIDTH     = 8,
  parameter int                         MEM_ADDR_WIDTH = 11,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR   = 32'hBFC00000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_instr,
  output logic [ADDRESS_WIDTH-1:0]  rsp_addr,
  output logic                      rsp_fault,
  output logic                      mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam logic [ADDRESS_WIDTH-1:0] WIN_LAST =
    RESET_VECTOR + ADDRESS_WIDTH'((1 << MEM_ADDR_WIDTH) - 4);
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP,
    FAULT
  } state_e;

  state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [MEM_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [1:0]                issue_cnt_q, issue_cnt_d;
  logic [1:0]                cap_cnt_q, cap_cnt_d;
  logic [3*DATA_WIDTH-1:0]   cap_q, cap_d;
  logic                      rd_pend_q, rd_pend_d;
  logic                      mem_en_q, mem_en_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_fault_q, rsp_fault_d;
  logic [31:0]               rsp_instr_q, rsp_instr_d;
  logic [ADDRESS_WIDTH-1:0]  rsp_addr_q, rsp_addr_d;

  logic                      accept;
  logic                      req_fault;
  logic                      last_capture;
  logic                      rsp_done;
  logic [MEM_ADDR_WIDTH-1:0] req_offset;
  logic [1:0]                issue_nxt;

  assign req_ready    = (state_q == IDLE) && !flush && !rst;
  assign accept       = req_valid && req_ready;
  assign req_fault    = (req_addr[1:0] != 2'b00) ||
                        (req_addr < RESET_VECTOR) || (req_addr > WIN_LAST);
  // The window base has zero low bits, so the offset is a narrow subtraction.
  assign req_offset   = req_addr[MEM_ADDR_WIDTH-1:0] - RESET_VECTOR[MEM_ADDR_WIDTH-1:0];
  assign last_capture = (state_q == FETCH) && rd_pend_q && (cap_cnt_q == 2'd3);
  assign rsp_done     = rsp_valid_q && rsp_ready;
  assign issue_nxt    = issue_cnt_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = req_fault ? FAULT : FETCH;
      FETCH:       if (last_capture) state_d = RESP;
      RESP, FAULT: if (rsp_done) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    addr_d      = addr_q;
    offset_d    = offset_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    cap_d       = cap_q;
    rd_pend_d   = 1'b0;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (req_fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_instr_d = NOP_INSTR;
            rsp_addr_d  = req_addr;
          end else begin
            offset_d    = req_offset;
            issue_cnt_d = 2'd0;
            cap_cnt_d   = 2'd0;
            mem_en_d    = 1'b1;
            mem_addr_d  = req_offset;
          end
        end
      end
      FETCH: begin
        // rd_pend marks that the store returns a byte in the following cycle.
        rd_pend_d = mem_en_q;
        if (mem_en_q) begin
          if (issue_cnt_q != 2'd3) begin
            issue_cnt_d = issue_nxt;
            mem_addr_d  = offset_q + MEM_ADDR_WIDTH'(issue_nxt);
          end else begin
            mem_en_d = 1'b0;
          end
        end
        if (rd_pend_q) begin
          cap_cnt_d = cap_cnt_q + 2'd1;
          case (cap_cnt_q)
            2'd0: cap_d[DATA_WIDTH-1:0]              = mem_rdata;
            2'd1: cap_d[2*DATA_WIDTH-1:DATA_WIDTH]   = mem_rdata;
            2'd2: cap_d[3*DATA_WIDTH-1:2*DATA_WIDTH] = mem_rdata;
            default: begin
              rsp_valid_d = 1'b1;
              rsp_fault_d = 1'b0;
              rsp_instr_d = {mem_rdata, cap_q};
              rsp_addr_d  = addr_q;
            end
          endcase
        end
      end
      RESP, FAULT: begin
        if (rsp_done) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (flush) begin
      rsp_valid_d = 1'b0;
      mem_en_d    = 1'b0;
      rd_pend_d   = 1'b0;
      issue_cnt_d = 2'd0;
      cap_cnt_d   = 2'd0;
      cap_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      offset_q    <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      cap_q       <= '0;
      rd_pend_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      offset_q    <= offset_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_q       <= cap_d;
      rd_pend_q   <= rd_pend_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;

endmodule
